// File: rtl/argmax_classifier.sv
// Sequential argmax over NUM_NEURONS captured scores with valid/ack result handshake.
// Optional build macro ARGMAX_RELU_EN clamps negative scores to zero at capture.
module argmax_classifier #(
   parameter int unsigned NUM_NEURONS  = 10,
   parameter int unsigned OUTPUT_WIDTH = 26,
   parameter int unsigned IDX_WIDTH    = 4
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [NUM_NEURONS*OUTPUT_WIDTH-1:0] IN_SCORES,
   input  logic [NUM_NEURONS-1:0]              in_done,
   input  logic                                ack,
   output logic [IDX_WIDTH-1:0]                CLASS,
   output logic [OUTPUT_WIDTH-1:0]             MAX_SCORE,
   output logic                                valid,
   output logic                                busy,
   output logic                                overrun
);

   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_NEURONS - 1);

   typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_e;

   state_e                  state_q, state_d;
   logic                    done_q, done_d;
   logic [OUTPUT_WIDTH-1:0] scores_q [NUM_NEURONS];
   logic [OUTPUT_WIDTH-1:0] scores_d [NUM_NEURONS];
   logic [OUTPUT_WIDTH-1:0] cap_scores [NUM_NEURONS];
   logic [OUTPUT_WIDTH-1:0] max_q, max_d;
   logic [IDX_WIDTH-1:0]    idx_q, idx_d;
   logic [IDX_WIDTH-1:0]    cnt_q, cnt_d;
   logic [IDX_WIDTH-1:0]    class_q, class_d;
   logic [OUTPUT_WIDTH-1:0] max_score_q, max_score_d;
   logic                    valid_q, valid_d;
   logic                    busy_q, busy_d;
   logic                    overrun_q, overrun_d;

   logic                    all_done;
   logic                    start;
   logic                    capture;
   logic                    greater;
   logic [OUTPUT_WIDTH-1:0] cur_score;
   logic [OUTPUT_WIDTH-1:0] scan_max;
   logic [IDX_WIDTH-1:0]    scan_idx;

   // Unpack scores as they would be stored on capture
   always_comb begin
      for (int unsigned n = 0; n < NUM_NEURONS; n++) begin
         cap_scores[n] = IN_SCORES[n*OUTPUT_WIDTH +: OUTPUT_WIDTH];
`ifdef ARGMAX_RELU_EN
         if (cap_scores[n][OUTPUT_WIDTH-1]) cap_scores[n] = '0;
`endif
      end
   end

   // One-step compare; strict greater-than keeps the lower index on ties
   always_comb begin
      cur_score = scores_q[cnt_q];
      greater   = $signed(cur_score) > $signed(max_q);
      scan_max  = greater ? cur_score : max_q;
      scan_idx  = greater ? cnt_q : idx_q;
   end

   always_comb begin
      state_d     = state_q;
      scores_d    = scores_q;
      max_d       = max_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      class_d     = class_q;
      max_score_d = max_score_q;
      valid_d     = valid_q;
      busy_d      = busy_q;
      overrun_d   = overrun_q;
      all_done    = &in_done;
      done_d      = all_done;
      start       = all_done && !done_q;
      capture     = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) capture = 1'b1;
         end
         SCAN: begin
            max_d = scan_max;
            idx_d = scan_idx;
            cnt_d = cnt_q + IDX_WIDTH'(1);
            if (start) overrun_d = 1'b1;
            if (cnt_q == LAST_IDX) begin
               class_d     = scan_idx;
               max_score_d = scan_max;
               valid_d     = 1'b1;
               state_d     = HOLD;
            end
         end
         HOLD: begin
            if (ack) begin
               valid_d = 1'b0;
               if (start) begin
                  capture = 1'b1;
               end else begin
                  busy_d  = 1'b0;
                  state_d = IDLE;
               end
            end else if (start) begin
               overrun_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (capture) begin
         scores_d = cap_scores;
         max_d    = cap_scores[0];
         idx_d    = '0;
         cnt_d    = IDX_WIDTH'(1);
         busy_d   = 1'b1;
         state_d  = SCAN;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         done_q      <= 1'b0;
         scores_q    <= '{default: '0};
         max_q       <= '0;
         idx_q       <= '0;
         cnt_q       <= '0;
         class_q     <= '0;
         max_score_q <= '0;
         valid_q     <= 1'b0;
         busy_q      <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         done_q      <= done_d;
         scores_q    <= scores_d;
         max_q       <= max_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         class_q     <= class_d;
         max_score_q <= max_score_d;
         valid_q     <= valid_d;
         busy_q      <= busy_d;
         overrun_q   <= overrun_d;
      end
   end

   assign CLASS     = class_q;
   assign MAX_SCORE = max_score_q;
   assign valid     = valid_q;
   assign busy      = busy_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_argmax_classifier.sv
// Scoreboard bench for argmax_classifier: stimulus pushes expected results, monitor pops on valid rise.
module tb_argmax_classifier;

   localparam int unsigned NN = 10;
   localparam int unsigned OW = 26;
   localparam int unsigned IW = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NN*OW-1:0]  IN_SCORES = '0;
   logic [NN-1:0]     in_done = '0;
   logic              ack = 1'b0;
   logic [IW-1:0]     CLASS;
   logic [OW-1:0]     MAX_SCORE;
   logic              valid;
   logic              busy;
   logic              overrun;

   argmax_classifier #(.NUM_NEURONS(NN), .OUTPUT_WIDTH(OW), .IDX_WIDTH(IW)) dut (
      .clk(clk), .rst(rst), .IN_SCORES(IN_SCORES), .in_done(in_done), .ack(ack),
      .CLASS(CLASS), .MAX_SCORE(MAX_SCORE), .valid(valid), .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [IW-1:0] cls;
      logic [OW-1:0] sc;
      int            cyc;
   } exp_t;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;
   logic        valid_prev = 1'b0;
   logic [OW-1:0] sc [NN];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic pack_scores();
      for (int n = 0; n < NN; n++) IN_SCORES[n*OW +: OW] = sc[n];
   endtask

   task automatic clear_scores();
      for (int n = 0; n < NN; n++) sc[n] = '0;
   endtask

   task automatic push_exp(input logic [IW-1:0] c, input logic [OW-1:0] s, input int at);
      exp_t e;
      e.cls = c;
      e.sc  = s;
      e.cyc = at;
      exp_q.push_back(e);
   endtask

   task automatic wait_valid();
      for (int i = 0; i < 40 && valid !== 1'b1; i++) @(negedge clk);
      chk("wait_valid", 32'(valid), 32'd1);
   endtask

   // Issue one start with ack held high and expect the given result after NN-1 further edges
   task automatic run_acked(input logic [IW-1:0] c, input logic [OW-1:0] s);
      @(negedge clk);
      ack = 1'b1;
      pack_scores();
      in_done = '1;
      push_exp(c, s, cyc + 10);
      wait_valid();
      @(negedge clk);
      chk("valid_drop_after_ack", 32'(valid), 32'd0);
      in_done = '0;
      @(negedge clk);
   endtask

   // Monitor: compare each new result against the head of the scoreboard
   always @(negedge clk) begin
      exp_t e;
      if (rst && valid === 1'b1 && valid_prev !== 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_valid", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("class", 32'(CLASS), 32'(e.cls));
            chk("max_score", 32'(MAX_SCORE), 32'(e.sc));
            if (e.cyc >= 0) chk("latency_edge", 32'(cyc), 32'(e.cyc));
         end
      end
      valid_prev = valid;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [OW-1:0] neg_exp;
      #2 rst = 1'b0;
      @(negedge clk);
      chk("rst_class", 32'(CLASS), 32'd0);
      chk("rst_max", 32'(MAX_SCORE), 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // Ascending scores: last neuron wins
      for (int n = 0; n < NN; n++) sc[n] = OW'(n * 32'h40000);
      run_acked(4'd9, 26'h240000);

      // Tie between 3 and 7 resolves to the lower index
      clear_scores();
      sc[3] = 26'h100000;
      sc[7] = 26'h100000;
      run_acked(4'd3, 26'h100000);

      // All negative
      for (int n = 0; n < NN; n++) sc[n] = OW'(-(n + 1) * 32'h40000);
`ifdef ARGMAX_RELU_EN
      neg_exp = 26'h0;
`else
      neg_exp = 26'h3FC0000;
`endif
      run_acked(4'd0, neg_exp);

      // Overrun: start during SCAN, then in HOLD without ack
      ack = 1'b0;
      clear_scores();
      for (int n = 0; n < NN; n++) sc[n] = 26'h1000;
      sc[5] = 26'h80000;
      pack_scores();
      in_done = '1;
      push_exp(4'd5, 26'h80000, cyc + 10);
      @(negedge clk);
      in_done = '0;
      repeat (2) @(negedge clk);
      in_done = '1;
      @(negedge clk);
      chk("overrun_scan", 32'(overrun), 32'd1);
      chk("busy_scan", 32'(busy), 32'd1);
      in_done = '0;
      wait_valid();
      clear_scores();
      sc[2] = 26'h200000;
      pack_scores();
      in_done = '1;
      @(negedge clk);
      chk("hold_valid", 32'(valid), 32'd1);
      chk("hold_class", 32'(CLASS), 32'd5);
      chk("hold_max", 32'(MAX_SCORE), 32'h80000);
      chk("overrun_hold", 32'(overrun), 32'd1);
      in_done = '0;
      @(negedge clk);
      // ack coincident with a fresh start: new scan, no extra overrun side effects
      in_done = '1;
      ack = 1'b1;
      push_exp(4'd2, 26'h200000, cyc + 10);
      @(negedge clk);
      chk("restart_valid", 32'(valid), 32'd0);
      chk("restart_busy", 32'(busy), 32'd1);
      wait_valid();
      chk("overrun_sticky", 32'(overrun), 32'd1);
      in_done = '0;
      @(negedge clk);
      chk("post_ack_busy", 32'(busy), 32'd0);

      // Long HOLD with scores toggling underneath
      ack = 1'b0;
      clear_scores();
      sc[7] = 26'h123456;
      pack_scores();
      in_done = '1;
      push_exp(4'd7, 26'h123456, cyc + 10);
      @(negedge clk);
      in_done = '0;
      wait_valid();
      for (int i = 0; i < 20; i++) begin
         for (int n = 0; n < NN; n++) IN_SCORES[n*OW +: OW] = OW'($urandom);
         @(negedge clk);
         chk("stable_valid", 32'(valid), 32'd1);
         chk("stable_class", 32'(CLASS), 32'd7);
         chk("stable_max", 32'(MAX_SCORE), 32'h123456);
      end
      ack = 1'b1;
      @(negedge clk);
      chk("hold_release_valid", 32'(valid), 32'd0);
      chk("hold_release_busy", 32'(busy), 32'd0);

      // Asynchronous reset in the middle of a scan (cnt = 5)
      for (int n = 0; n < NN; n++) sc[n] = OW'(n * 32'h40000);
      pack_scores();
      in_done = '1;
      repeat (5) @(negedge clk);
      #1 rst = 1'b0;
      #1;
      chk("arst_class", 32'(CLASS), 32'd0);
      chk("arst_max", 32'(MAX_SCORE), 32'd0);
      chk("arst_valid", 32'(valid), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_overrun", 32'(overrun), 32'd0);
      @(negedge clk);
      push_exp(4'd9, 26'h240000, cyc + 10);
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_busy", 32'(busy), 32'd1);
      wait_valid();
      @(negedge clk);
      in_done = '0;

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
